// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl
// Description : Load/store unit for a word-wide DataMemory. Sub-word stores
//               are done as read-modify-write; loads are sign/zero extended.
//               Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_we,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    logic [1:0]      r_state;
    logic            r_we;
    logic [2:0]      r_funct3;
    logic [1:0]      r_off;
    logic [15:0]     r_wdata_lo;
    logic [XLEN-1:0] r_rsp_rdata;
    logic            r_rsp_err;
    logic [XLEN-1:0] r_mem_addr;
    logic [XLEN-1:0] r_mem_wdata;
    logic            r_mem_we;

    logic            w_illegal;
    logic            w_half;
    logic            w_word;
    logic            w_trap;
    logic            w_err_flag;
    logic [XLEN-1:0] w_req_addr;
    logic [7:0]      w_byte;
    logic [15:0]     w_half_data;
    logic [XLEN-1:0] w_load;
    logic [XLEN-1:0] w_merged;

    always_comb begin
        case (req_funct3)
            F_B, F_H, F_W: w_illegal = 1'b0;
            F_BU, F_HU:    w_illegal = req_we;
            default:       w_illegal = 1'b1;
        endcase
        w_half = (req_funct3[1:0] == 2'b01);
        w_word = (req_funct3[1:0] == 2'b10);
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign = (w_half && req_addr[0]) || (w_word && (req_addr[1:0] != 2'b00));
    assign w_trap     = w_illegal || w_misalign;
    assign w_err_flag = w_trap;
    assign w_req_addr = req_addr;
`else
    // Misaligned addresses are silently rounded down to the access size.
    assign w_trap     = w_illegal;
    assign w_err_flag = 1'b0;
    always_comb begin
        w_req_addr = req_addr;
        if (w_half) w_req_addr[0]   = 1'b0;
        if (w_word) w_req_addr[1:0] = 2'b00;
    end
`endif

    always_comb begin
        w_byte      = mem_rdata[{r_off, 3'b000} +: 8];
        w_half_data = mem_rdata[{r_off[1], 4'b0000} +: 16];
        case (r_funct3)
            F_B:     w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
            F_H:     w_load = {{(XLEN-16){w_half_data[15]}}, w_half_data};
            F_BU:    w_load = {{(XLEN-8){1'b0}}, w_byte};
            F_HU:    w_load = {{(XLEN-16){1'b0}}, w_half_data};
            default: w_load = mem_rdata;
        endcase
    end

    always_comb begin
        w_merged = mem_rdata;
        if (r_funct3 == F_B) begin
            w_merged[{r_off, 3'b000} +: 8] = r_wdata_lo[7:0];
        end else begin
            w_merged[{r_off[1], 4'b0000} +: 16] = r_wdata_lo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_funct3    <= 3'b000;
            r_off       <= 2'b00;
            r_wdata_lo  <= 16'h0000;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we        <= req_we;
                        r_funct3    <= req_funct3;
                        r_off       <= w_req_addr[1:0];
                        r_wdata_lo  <= req_wdata[15:0];
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= w_err_flag;
                        if (w_trap) begin
                            r_state <= S_RESP;
                        end else begin
                            r_state    <= S_ACCESS;
                            r_mem_addr <= {w_req_addr[XLEN-1:2], 2'b00};
                            // Full-word stores need no read, so the write is issued now.
                            if (req_we && (req_funct3 == F_W)) begin
                                r_mem_we    <= 1'b1;
                                r_mem_wdata <= req_wdata;
                            end
                        end
                    end
                end
                S_ACCESS: begin
                    if (!r_we) begin
                        r_rsp_rdata <= w_load;
                        r_state     <= S_RESP;
                    end else if (r_funct3 == F_W) begin
                        r_mem_we <= 1'b0;
                        r_state  <= S_RESP;
                    end else begin
                        r_mem_we    <= 1'b1;
                        r_mem_wdata <= w_merged;
                        r_state     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_mem_we <= 1'b0;
                    r_state  <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we    = r_mem_we;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_ctrl
// Description : Directed self-checking bench for lsu_ctrl with a small
//               word-wide memory model attached to the memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:15];
    int checks = 0;
    int failures = 0;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    lsu_ctrl #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[5:2]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One complete request/response with rsp_ready held high.
    task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input int exp_lat, input int exp_wes);
        int lat;
        int wes;
        @(negedge clk);
        chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        wes = 0;
        while (!rsp_valid && lat < 10) begin
            if (mem_we) wes++;
            @(posedge clk); #1;
            lat++;
        end
        if (mem_we) wes++;
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".we_cycles"}, 32'(wes), 32'(exp_wes));
        chk({tag, ".rdata"}, rsp_rdata, exp_rd);
        chk({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
        @(posedge clk); #1;
        chk({tag, ".idle"}, {30'd0, req_ready, rsp_valid}, 32'd2);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst.req_ready", 32'(req_ready), 32'd1);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.rsp_rdata", rsp_rdata, 32'd0);
        chk("rst.rsp_err", 32'(rsp_err), 32'd0);
        chk("rst.mem_we", 32'(mem_we), 32'd0);
        chk("rst.mem_wdata", mem_wdata, 32'd0);
        chk("rst.mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        txn("sw4", 1'b1, 3'b010, 32'h4, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1);
        chk("mem4.after_sw", mem[1], 32'hDEADBEEF);
        txn("lw4", 1'b0, 3'b010, 32'h4, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);

        txn("sw8", 1'b1, 3'b010, 32'h8, 32'h11223344, 32'h0, 1'b0, 2, 1);
        txn("sb9", 1'b1, 3'b000, 32'h9, 32'h123456AA, 32'h0, 1'b0, 3, 1);
        chk("mem8.after_sb", mem[2], 32'h1122AA44);
        txn("lb9", 1'b0, 3'b000, 32'h9, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 0);
        txn("lbu9", 1'b0, 3'b100, 32'h9, 32'h0, 32'h000000AA, 1'b0, 2, 0);

        txn("shA", 1'b1, 3'b001, 32'hA, 32'hCAFEBEEF, 32'h0, 1'b0, 3, 1);
        chk("mem8.after_sh", mem[2], 32'hBEEFAA44);
        txn("lhA", 1'b0, 3'b001, 32'hA, 32'h0, 32'hFFFFBEEF, 1'b0, 2, 0);
        txn("lhuA", 1'b0, 3'b101, 32'hA, 32'h0, 32'h0000BEEF, 1'b0, 2, 0);
        txn("lb8", 1'b0, 3'b000, 32'h8, 32'h0, 32'h00000044, 1'b0, 2, 0);
        txn("lbB", 1'b0, 3'b000, 32'hB, 32'h0, 32'hFFFFFFBE, 1'b0, 2, 0);
        txn("lh8", 1'b0, 3'b001, 32'h8, 32'h0, 32'hFFFFAA44, 1'b0, 2, 0);

`ifdef LSU_MISALIGN_TRAP_EN
        txn("lw6", 1'b0, 3'b010, 32'h6, 32'h0, 32'h0, 1'b1, 1, 0);
`else
        txn("lw6", 1'b0, 3'b010, 32'h6, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);
`endif
        txn("ld_f3_011", 1'b0, 3'b011, 32'h4, 32'h0, 32'h0, TRAP, 1, 0);
        txn("st_f3_100", 1'b1, 3'b100, 32'h4, 32'h0, 32'h0, TRAP, 1, 0);
        chk("mem4.after_illegal_st", mem[1], 32'hDEADBEEF);

        // Backpressure: a second request waits until the response handshake.
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8;
        @(posedge clk); #1;
        req_addr = 32'h4;
        @(posedge clk); #1;
        chk("bp.rsp_valid", 32'(rsp_valid), 32'd1);
        chk("bp.rdata", rsp_rdata, 32'hBEEFAA44);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp.hold", {rsp_valid, req_ready, mem_we}, 32'h4);
            chk("bp.hold_rdata", rsp_rdata, 32'hBEEFAA44);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp.after_hs", {30'd0, req_ready, rsp_valid}, 32'd2);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp.accepted", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("bp.second_valid", 32'(rsp_valid), 32'd1);
        chk("bp.second_rdata", rsp_rdata, 32'hDEADBEEF);
        @(posedge clk); #1;

        // Reset while the RMW write is pending.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h8; req_wdata = 32'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("rstw.we_in_write", 32'(mem_we), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstw.mem_we", 32'(mem_we), 32'd0);
        chk("rstw.flags", {28'd0, req_ready, rsp_valid, rsp_err, 1'b0}, 32'h8);
        chk("rstw.rsp_rdata", rsp_rdata, 32'd0);
        chk("rstw.mem_wdata", mem_wdata, 32'd0);
        chk("rstw.mem_addr", mem_addr, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rstw.mem8", mem[2], 32'hBEEFAA44);
        txn("lw8.after_rst", 1'b0, 3'b010, 32'h8, 32'h0, 32'hBEEFAA44, 1'b0, 2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit between the core datapath and the word-wide `DataMemory`. It takes one RISC-V load or store request at a time and performs sub-word (byte/halfword) stores as a read-modify-write, because `DataMemory` only writes full words. Loads are returned sign- or zero-extended. It drives the memory's `addr`/`write_data`/`WE` and consumes its asynchronous `read_data`.

## Interface
Parameters:
- `XLEN`, 32: data and address width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  the unit can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V funct3:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU;
  - stores: 000 SB, 001 SH, 010 SW.
- `req_addr`  in  XLEN  byte address.
- `req_wdata`  in  XLEN  store data; only the low byte or halfword is used for SB/SH.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  the core accepts the response.
- `rsp_rdata`  out  XLEN  extended load data; 0 for stores.
- `rsp_err`  out  1  misaligned access (see Configuration).
- `mem_addr`  out  XLEN  word address to `DataMemory`, always `{addr[31:2],2'b00}`.
- `mem_wdata`  out  XLEN  word to write.
- `mem_we`  out  1  write enable to `DataMemory`.
- `mem_rdata`  in  XLEN  asynchronous read data from `DataMemory`.

## Operation
State machine: IDLE, ACCESS, WRITE, RESP.

- **IDLE**
  - `req_ready`=1. On `req_valid && req_ready`, latch `req_we`, `req_funct3`, `req_addr` and `req_wdata`.
  - Go to ACCESS, or to RESP with `rsp_err`=1 if the access is misaligned and trapping is enabled.
- **ACCESS**
  - `mem_addr` = latched word address.
  - Load: select the lane from `mem_rdata` using `addr[1:0]`, extend it, register it into `rsp_rdata`, go to RESP.
  - SW: `mem_we`=1, `mem_wdata`=`req_wdata`, go to RESP.
  - SB/SH: capture `mem_rdata`, merge the new byte/halfword into the lane selected by `addr[1:0]`, go to WRITE.
- **WRITE**: `mem_we`=1, `mem_wdata`=merged word, go to RESP.
- **RESP**
  - `rsp_valid`=1; `rsp_rdata` and `rsp_err` are held stable.
  - On `rsp_ready`, go to IDLE.

Lane and extension rules:
- Byte lane = `addr[1:0]`; halfword lane = `addr[1]`.
- LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.

Alignment:
- LH/LHU/SH are misaligned when `addr[0]`=1.
- LW/SW are misaligned when `addr[1:0]`≠0.

Illegal funct3 values (011, 110, 111, and stores with 1xx) are treated as misaligned: `rsp_err` path, no memory write.

Only one request is in flight. `req_ready`=0 in every state except IDLE.

## Timing
- Reset values: state=IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `mem_we`=0, `mem_wdata`=0, `mem_addr`=0.
- Latency from the accept edge to `rsp_valid`=1:
  - loads and SW: 2 cycles;
  - SB/SH: 3 cycles;
  - trapped misaligned access: 1 cycle.
- `mem_we` is a registered output, high for exactly one cycle per store. The write commits on the following rising edge inside `DataMemory`.
- Back-to-back throughput: a new request can be accepted in the cycle after RESP handshakes.
- Backpressure: while `rsp_ready`=0 the unit stays in RESP indefinitely, with no memory activity.
- Reset mid-operation: `rst_n` low forces `mem_we`=0 immediately (asynchronously), so a pending RMW write is dropped and memory is unchanged. The latched request is discarded.

## Configuration
`LSU_MISALIGN_TRAP_EN`:
- **Defined:** a misaligned access sets `rsp_err`=1 and `rsp_rdata`=0, makes no memory access, and goes straight to RESP.
- **Undefined:**
  - `rsp_err` is tied to 0.
  - The address's low bits are forced to alignment: halfword accesses clear `addr[0]`; word accesses clear `addr[1:0]`.
  - The access then proceeds normally.

## Test plan
- SW 0xDEADBEEF to 0x4, then LW 0x4 → `rsp_rdata`=0xDEADBEEF; `mem_we` high exactly one cycle; response 2 cycles after accept.
- SW 0x11223344 to 0x8, then SB 0xAA to 0x9 → word at 0x8 = 0x1122AA44.
  - LB 0x9 → 0xFFFFFFAA.
  - LBU 0x9 → 0x000000AA.
- Starting from 0x1122AA44, SH 0xBEEF to 0xA → word = 0xBEEFAA44.
  - LH 0xA → 0xFFFFBEEF.
  - LHU 0xA → 0x0000BEEF.
- LW 0x6:
  - with the macro: `rsp_err`=1, `rsp_rdata`=0, no `mem_we`, response 1 cycle after accept;
  - without the macro: `rsp_rdata`=0xDEADBEEF (the word at 0x4), `rsp_err`=0.
- Hold `rsp_ready`=0 for 3 cycles after an LW → `rsp_valid` and `rsp_rdata` stay stable, `req_ready`=0, and a new request is accepted only after the handshake.
- Assert `rst_n`=0 while in WRITE during an SB → `mem_we` drops immediately, the memory word is unchanged, and all outputs return to their reset values.
